uart_rx_param: RTL and testbench

// - Parametrised UART receiver; successor to fixed 8-bit RX. Sits between the rx pin and the RX FIFO of the AXI-Lite UART.
// - Adds configurable data width/oversampling, input synchroniser, false-start rejection, runtime stop-bit select.
// - Adds per-word parity/framing error flags and a valid/ready output handshake with overrun detection.

---
 rtl/uart_rx_param.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with synchroniser, false-start rejection and valid/ready output.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each mid-bit sample.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 a_resetn,
  input  logic                 rx,
  input  logic                 b_tick,
  input  logic [1:0]           parity,
  input  logic                 stop2,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] MID_DEC = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] BIT_END = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             hist_q, hist_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [1:0]             pmode_q, pmode_d;
  logic                   stop2_q, stop2_d;
  logic                   perr_p_q, perr_p_d;
  logic                   ferr_p_q, ferr_p_d;
  logic                   armed_q, armed_d;
  logic [DATA_BITS-1:0]   dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   pe_q, pe_d;
  logic                   fe_q, fe_d;
  logic                   ovr_q, ovr_d;

  logic rxs;
  logic samp;
  logic par_en;
  logic done;
  logic ferr_now;
  logic take;

  assign rxs    = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  assign hist_d = b_tick ? {hist_q[0], rxs} : hist_q;
  assign par_en = pmode_q[0] ^ pmode_q[1];

  // Decision is taken one tick after mid so the vote can see mid+1.
`ifdef UART_RX_MAJORITY_EN
  assign samp = (hist_q[1] & hist_q[0]) |
                (hist_q[1] & rxs) |
                (hist_q[0] & rxs);
`else
  assign samp = hist_q[0];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pmode_d  = pmode_q;
    stop2_d  = stop2_q;
    perr_p_d = perr_p_q;
    ferr_p_d = ferr_p_q;
    ferr_now = ferr_p_q;
    done     = 1'b0;
    // A new start needs rx seen high while idle, so breaks don't retrigger.
    armed_d  = (state_q == S_IDLE) & (armed_q | rxs);
    unique case (state_q)
      S_IDLE: begin
        if (armed_q && !rxs) begin
          state_d  = S_START;
          cnt_d    = '0;
          bit_d    = '0;
          pmode_d  = parity;
          stop2_d  = stop2;
          perr_p_d = 1'b0;
          ferr_p_d = 1'b0;
        end
      end
      S_START: begin
        if (b_tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == MID_DEC) begin
            cnt_d   = '0;
            state_d = samp ? S_IDLE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (b_tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BIT_END) begin
            cnt_d   = '0;
            shift_d = {samp, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
              bit_d   = '0;
              state_d = par_en ? S_PARITY : S_STOP;
            end
          end
        end
      end
      S_PARITY: begin
        if (b_tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BIT_END) begin
            cnt_d    = '0;
            perr_p_d = pmode_q[0] ? ~(^shift_q ^ samp)
                                  : (^shift_q ^ samp);
            state_d  = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (b_tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BIT_END) begin
            cnt_d    = '0;
            ferr_now = ferr_p_q | ~samp;
            ferr_p_d = ferr_now;
            if (stop2_q && bit_q == '0) begin
              bit_d = BW'(1);
            end else begin
              bit_d   = '0;
              state_d = S_IDLE;
              done    = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    take    = valid_q & rx_ready;
    valid_d = valid_q & ~take;
    dout_d  = dout_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = 1'b0;
    if (done) begin
      if (!valid_q || take) begin
        dout_d  = shift_q;
        pe_d    = perr_p_q;
        fe_d    = ferr_now;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q  <= S_IDLE;
      sync_q   <= '1;
      hist_q   <= '1;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      pmode_q  <= '0;
      stop2_q  <= 1'b0;
      perr_p_q <= 1'b0;
      ferr_p_q <= 1'b0;
      armed_q  <= 1'b0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      pmode_q  <= pmode_d;
      stop2_q  <= stop2_d;
      perr_p_q <= perr_p_d;
      ferr_p_q <= ferr_p_d;
      armed_q  <= armed_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign rx_valid   = valid_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: vector table of frames plus
// hand sequences for overrun and mid-frame reset.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       a_resetn;
  logic       rx;
  logic       b_tick;
  logic [1:0] parity;
  logic       stop2;
  logic       rx_ready;
  logic [7:0] dout;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;
  int ovr_cnt = 0;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GL_EXP = 8'hFF;
`else
  localparam logic [7:0] GL_EXP = 8'hFB;
`endif

  uart_rx_param #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .a_resetn  (a_resetn),
    .rx        (rx),
    .b_tick    (b_tick),
    .parity    (parity),
    .stop2     (stop2),
    .rx_ready  (rx_ready),
    .dout      (dout),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (a_resetn && overrun) ovr_cnt++;

  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    logic       pf;
    logic       two;
    logic       s1;
    logic       s2;
    int         gbit;
    int         xlow;
    logic       glitch;
    logic       ev;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [8:0] act,
                     input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm,
                            input logic pf, input logic two,
                            input logic s1, input logic s2,
                            input int gbit, input int xlow);
    logic p;
    parity = pm;
    stop2  = two;
    drive(1'b0, 16);
    // scramble config mid-frame; receiver must use latched values
    parity = ~pm;
    stop2  = ~two;
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) begin
        drive(d[i], 9);
        drive(~d[i], 1);
        drive(d[i], 6);
      end else begin
        drive(d[i], 16);
      end
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      p = (^d) ^ (pm == 2'b01) ^ pf;
      drive(p, 16);
    end
    drive(s1, 16);
    if (two) drive(s2, 16);
    if (xlow > 0) drive(1'b0, 16 * xlow);
    drive(1'b1, 16);
    parity = pm;
    stop2  = two;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (rx_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic consume(input string nm);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    chk({nm, "_drop"}, {8'h0, rx_valid}, 9'h0);
  endtask

  task automatic expect_word(input string nm, input logic [7:0] ed,
                             input logic epe, input logic efe);
    bit ok;
    wait_valid(ok);
    chk({nm, "_valid"}, {8'h0, rx_valid}, 9'h1);
    if (ok) begin
      chk({nm, "_dout"}, {1'b0, dout}, {1'b0, ed});
      chk({nm, "_perr"}, {8'h0, parity_err}, {8'h0, epe});
      chk({nm, "_ferr"}, {8'h0, frame_err}, {8'h0, efe});
      consume(nm);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_dout"}, {1'b0, dout}, 9'h0);
    chk({nm, "_valid"}, {8'h0, rx_valid}, 9'h0);
    chk({nm, "_perr"}, {8'h0, parity_err}, 9'h0);
    chk({nm, "_ferr"}, {8'h0, frame_err}, 9'h0);
    chk({nm, "_ovr"}, {8'h0, overrun}, 9'h0);
  endtask

  initial begin
    int base;
    vt[0]  = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0,
               1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1]  = '{8'h3C, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0,
               1'b1, 8'h3C, 1'b0, 1'b0};
    vt[2]  = '{8'h3C, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0,
               1'b1, 8'h3C, 1'b1, 1'b0};
    vt[3]  = '{8'h81, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0,
               1'b1, 8'h81, 1'b0, 1'b1};
    vt[4]  = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0,
               1'b1, 8'h55, 1'b0, 1'b0};
    vt[5]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 1'b1,
               1'b0, 8'h00, 1'b0, 1'b0};
    vt[6]  = '{8'h12, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0,
               1'b1, 8'h12, 1'b0, 1'b0};
    vt[7]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1, 3, 1'b0,
               1'b1, 8'h00, 1'b0, 1'b1};
    vt[8]  = '{8'h07, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0,
               1'b1, 8'h07, 1'b0, 1'b0};
    vt[9]  = '{8'h07, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0,
               1'b1, 8'h07, 1'b1, 1'b0};
    vt[10] = '{8'h5A, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0,
               1'b1, 8'h5A, 1'b0, 1'b0};
    vt[11] = '{8'hFF, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2, 0, 1'b0,
               1'b1, GL_EXP, 1'b0, 1'b0};

    a_resetn = 1'b0;
    rx       = 1'b1;
    b_tick   = 1'b1;
    parity   = 2'b00;
    stop2    = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    a_resetn = 1'b1;
    drive(1'b1, 16);

    for (int i = 0; i < 12; i++) begin
      rx_ready = 1'b0;
      if (vt[i].glitch) begin
        drive(1'b0, 5);
        drive(1'b1, 32);
      end else begin
        send_frame(vt[i].d, vt[i].pm, vt[i].pf, vt[i].two,
                   vt[i].s1, vt[i].s2, vt[i].gbit, vt[i].xlow);
      end
      if (vt[i].ev)
        expect_word($sformatf("v%0d", i), vt[i].ed, vt[i].epe, vt[i].efe);
      else
        chk($sformatf("v%0d_novalid", i), {8'h0, rx_valid}, 9'h0);
    end

    // overrun: second word dropped while first is unaccepted
    base = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    chk("ovr_valid", {8'h0, rx_valid}, 9'h1);
    chk("ovr_dout", {1'b0, dout}, 9'h011);
    chk("ovr_pulses", 9'(ovr_cnt - base), 9'h1);
    consume("ovr");

    // reset during data bit 4 with an unaccepted word held
    send_frame(8'h33, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    chk("pre_rst_valid", {8'h0, rx_valid}, 9'h1);
    drive(1'b0, 16);
    for (int i = 0; i < 4; i++) drive(((8'h7E >> i) & 8'h1) != 0, 16);
    drive(1'b1, 8);
    a_resetn = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    a_resetn = 1'b1;
    drive(1'b1, 48);
    chk("midrst_nopartial", {8'h0, rx_valid}, 9'h0);
    send_frame(8'h7E, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
    expect_word("post_rst", 8'h7E, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
